// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: bus widths, enable
// levels and default sizing.
package regfile_wr_arbiter_pkg;
  localparam int REG_ADDR_BUS = 5;
  localparam int REG_BUS      = 32;

  localparam logic               WRITE_ENABLE  = 1'b1;
  localparam logic               WRITE_DISABLE = 1'b0;
  localparam logic [REG_BUS-1:0] ZERO_WORD     = '0;
  localparam logic               RST_ENABLE_N  = 1'b0;

  localparam int DEF_DEPTH        = 2;
  localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the primary/secondary write sources, decode hazard lookup and the
// arbitrated register-file write port.
interface regfile_wr_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_waddr;
  logic [DW-1:0] lu_wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          pend_hit1;
  logic          pend_hit2;
  logic          stall_req;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    input  raddr1, raddr2,
    output lu_ready, pend_hit1, pend_hit2, stall_req,
    output we, waddr, wdata
  );

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    output raddr1, raddr2,
    input  lu_ready, pend_hit1, pend_hit2, stall_req,
    input  we, waddr, wdata
  );
endinterface

// File: rtl/regfile_wr_arbiter_wr_fifo.sv
// Small FIFO holding queued secondary writes; exposes per-entry valid bits and
// addresses so decode can see which registers are still pending.
module regfile_wr_arbiter_wr_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = REG_ADDR_BUS,
  parameter int DW    = REG_BUS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic                     empty,
  output logic                     full,
  output logic [DEPTH-1:0]         valid,
  output logic [DEPTH-1:0][AW-1:0] addrs
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // NOTE: the entry storage has no reset; only pointers, count and valid bits
  // are reset, and every consumer of an entry qualifies it with its valid bit.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) addrs[i] = mem_addr[i];
  end

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port: the writeback stage always wins, queued
// long-latency results drain in its idle cycles, and a starved head raises stall_req.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int AW           = REG_ADDR_BUS,
  parameter int DW           = REG_BUS
) (
  input logic                clk,
  input logic                rst,
  regfile_wr_arbiter_if.slave bus
);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic                     in_reset, prim_active, push, pop;
  logic [AW-1:0]            head_addr;
  logic [DW-1:0]            head_data;
  logic                     empty, full;
  logic [DEPTH-1:0]         valid;
  logic [DEPTH-1:0][AW-1:0] addrs;
  logic [AGE_W-1:0]         age;

  // Outputs must read idle while reset is held, even though the primary path is combinational.
  assign in_reset    = (rst == RST_ENABLE_N);
  assign prim_active = !in_reset && bus.pipe_we && (bus.pipe_waddr != '0);
  assign bus.lu_ready = !in_reset && !full;
  assign push        = bus.lu_valid && bus.lu_ready && (bus.lu_waddr != '0);
  assign pop         = !in_reset && !empty && !prim_active;

  regfile_wr_arbiter_wr_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (bus.lu_waddr),
    .push_data (bus.lu_wdata),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .empty     (empty),
    .full      (full),
    .valid     (valid),
    .addrs     (addrs)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    bus.we    = WRITE_DISABLE;
    bus.waddr = '0;
    bus.wdata = DW'(ZERO_WORD);
    if (prim_active) begin
      bus.we    = WRITE_ENABLE;
      bus.waddr = bus.pipe_waddr;
      bus.wdata = bus.pipe_wdata;
    end else if (pop) begin
      bus.we    = WRITE_ENABLE;
      bus.waddr = head_addr;
      bus.wdata = head_data;
    end
  end

  always_comb begin
    bus.pend_hit1 = 1'b0;
    bus.pend_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (addrs[i] == bus.raddr1)) bus.pend_hit1 = 1'b1;
      if (valid[i] && (addrs[i] == bus.raddr2)) bus.pend_hit2 = 1'b1;
    end
    if (bus.raddr1 == '0) bus.pend_hit1 = 1'b0;
    if (bus.raddr2 == '0) bus.pend_hit2 = 1'b0;
  end

  // Age measures how long the current head has waited; stall follows one cycle behind.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE_N) begin
      age           <= '0;
      bus.stall_req <= 1'b0;
    end else begin
      bus.stall_req <= !pop && (age == AGE_W'(STARVE_LIMIT));
      if (empty || pop)                   age <= '0;
      else if (age != AGE_W'(STARVE_LIMIT)) age <= age + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter against a queue-based model of the
// write arbitration, pending-hazard and starvation rules.
module tb_regfile_wr_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ent_t q[$];
  int   m_age = 0;
  bit   m_stall = 1'b0;

  regfile_wr_arbiter_if #(.AW(5), .DW(32)) bus ();

  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .AW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare outputs, then advance the model at posedge.
  task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit prim, rdy, do_pop, do_push, h1, h2, e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    @(negedge clk);
    bus.pipe_we = pwe; bus.pipe_waddr = pa; bus.pipe_wdata = pd;
    bus.lu_valid = lv; bus.lu_waddr = la; bus.lu_wdata = ld;
    bus.raddr1 = r1; bus.raddr2 = r2;
    #1;
    prim = pwe && (pa != 0);
    rdy  = (q.size() < DEPTH);
    e_we = 1'b0; e_a = '0; e_d = '0;
    if (prim) begin
      e_we = 1'b1; e_a = pa; e_d = pd;
    end else if (q.size() > 0) begin
      e_we = 1'b1; e_a = q[0].a; e_d = q[0].d;
    end
    h1 = 1'b0; h2 = 1'b0;
    foreach (q[i]) begin
      if (r1 != 0 && q[i].a == r1) h1 = 1'b1;
      if (r2 != 0 && q[i].a == r2) h2 = 1'b1;
    end
    check("we", 32'(bus.we), 32'(e_we));
    check("waddr", 32'(bus.waddr), 32'(e_a));
    check("wdata", bus.wdata, e_d);
    check("lu_ready", 32'(bus.lu_ready), 32'(rdy));
    check("pend_hit1", 32'(bus.pend_hit1), 32'(h1));
    check("pend_hit2", 32'(bus.pend_hit2), 32'(h2));
    check("stall_req", 32'(bus.stall_req), 32'(m_stall));
    @(posedge clk);
    do_pop  = !prim && (q.size() > 0);
    do_push = lv && rdy && (la != 0);
    m_stall = !do_pop && (m_age == LIMIT);
    if (q.size() == 0 || do_pop) m_age = 0;
    else if (m_age < LIMIT) m_age++;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{a: la, d: ld});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'hDEADBEEF;
    bus.lu_valid = 1'b0; bus.lu_waddr = '0; bus.lu_wdata = '0;
    bus.raddr1 = '0; bus.raddr2 = '0;
    #3;
    check("rst_we", 32'(bus.we), 0);
    check("rst_waddr", 32'(bus.waddr), 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_ready", 32'(bus.lu_ready), 0);
    check("rst_stall", 32'(bus.stall_req), 0);
    @(negedge clk); rst = 1'b1;

    // Primary pass-through in the same cycle.
    step(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    #1;
    check("prim_we", 32'(bus.we), 1);
    check("prim_waddr", 32'(bus.waddr), 3);
    check("prim_wdata", bus.wdata, 32'hDEADBEEF);
    check("prim_ready", 32'(bus.lu_ready), 1);

    // Secondary write appears one cycle after acceptance, then queue is empty.
    step(0, 0, 0, 1, 5'd7, 32'h12345678, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("drain_empty_we", 32'(bus.we), 0);

    // Fill both entries under a busy primary; third request is held off.
    step(1, 5'd1, 32'h1, 1, 5'd5, 32'h55, 0, 0);
    step(1, 5'd2, 32'h2, 1, 5'd6, 32'h66, 5'd5, 5'd6);
    #1;
    check("full_ready", 32'(bus.lu_ready), 0);
    check("full_hit1", 32'(bus.pend_hit1), 1);
    step(1, 5'd3, 32'h3, 1, 5'd9, 32'h99, 5'd9, 5'd5);
    idle(3);

    // Starvation: one queued entry behind a continuously busy primary.
    step(1, 5'd4, 32'h4, 1, 5'd10, 32'hAA, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 5'd4, 32'(i), 0, 0, 0, 5'd10, 0);
    #1;
    check("starve_stall", 32'(bus.stall_req), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("starve_release", 32'(bus.stall_req), 0);

    // Address-0 push and address-0 lookup.
    step(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0);
    step(1, 5'd0, 32'h77, 0, 0, 0, 0, 0);
    idle(1);

    // Asynchronous reset with two queued entries.
    step(1, 5'd1, 32'h1, 1, 5'd11, 32'hB1, 0, 0);
    step(1, 5'd1, 32'h1, 1, 5'd12, 32'hB2, 5'd11, 0);
    @(negedge clk);
    bus.pipe_we = 1'b0; bus.lu_valid = 1'b0; bus.raddr1 = 5'd11;
    #2 rst = 1'b0;
    #1;
    check("arst_we", 32'(bus.we), 0);
    check("arst_ready", 32'(bus.lu_ready), 0);
    check("arst_hit1", 32'(bus.pend_hit1), 0);
    q.delete(); m_age = 0; m_stall = 1'b0;
    @(negedge clk); rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 5'd11, 5'd12);
    idle(2);

    // Randomized traffic over a small address range to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage (primary) and a long-latency unit (LU: divider/load return, secondary).
- Primary writes pass straight through in the same cycle.
- Secondary results queue in a small FIFO and drain on cycles where the primary does not write.
- Provides pending-register hazard flags to decode, and a stall request to the pipeline controller when the queue head starves.

Parameters:
DEPTH, 2, secondary FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, cycles the FIFO head may wait before stall_req asserts
AW, 5, register address width (`RegAddrBus)
DW, 32, data width (`RegBus)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
pipe_we  in  1  primary write enable
pipe_waddr  in  AW  primary write address
pipe_wdata  in  DW  primary write data
lu_valid  in  1  secondary result valid
lu_ready  out  1  secondary can accept (registered FIFO not full)
lu_waddr  in  AW  secondary write address
lu_wdata  in  DW  secondary write data
raddr1  in  AW  decode read address 1
raddr2  in  AW  decode read address 2
pend_hit1  out  1  raddr1 matches a queued secondary write
pend_hit2  out  1  raddr2 matches a queued secondary write
stall_req  out  1  pipeline must stop issuing primary writes
we  out  1  regfile write enable
waddr  out  AW  regfile write address
wdata  out  DW  regfile write data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rst=0:
  - FIFO empty; count=0, age=0, stall_req=0.
  - we=0, waddr=0, wdata=0; lu_ready=0; pend_hit1/2=0.
- Primary path, combinational, 0-cycle latency:
  - A primary write is active when pipe_we=1 and pipe_waddr!=0.
  - When active: we=1, waddr/wdata = pipe_* in the same cycle.
  - pipe_we=1 with pipe_waddr=0 counts as idle.
- Secondary push:
  - At posedge, if lu_valid && lu_ready, push {lu_waddr, lu_wdata}.
  - If lu_waddr=0, the handshake completes but nothing is pushed.
- lu_ready = (count != DEPTH), from registered count.
  - When full, no push occurs even if a pop happens the same cycle.
- Secondary drain:
  - If FIFO is non-empty and no primary write is active, the outputs drive the FIFO head (we=1) and the head pops at posedge.
  - Minimum accept-to-write latency is 1 cycle. There is no bypass from lu_* to the outputs.
- Idle: if neither path is active, we=0, waddr=0, wdata=0.
- Simultaneous push and pop (not full) are both applied: count unchanged, pointers advance, wrap modulo DEPTH.
- Starvation:
  - age increments each cycle the FIFO is non-empty and the head does not pop, saturating at STARVE_LIMIT.
  - age clears to 0 on a pop or when the FIFO is empty.
  - stall_req is registered: it goes high the cycle after age reaches STARVE_LIMIT and drops the cycle after the head pops.
  - The primary still wins while stall_req=1. The pipeline honours the request by deasserting pipe_we.
- Hazards:
  - pend_hitN = (raddrN != 0) && some valid FIFO entry has waddr == raddrN. Combinational over valid entries only.
  - Decode stalls on pend_hit. Decode must not issue a primary write to an address with a queued secondary write (WAW ordering is decode's responsibility).
- Reset asserted mid-operation discards all queued entries immediately (asynchronous); nothing pending is written.

Decomposition:
- Shared defines header: RegAddrBus, RegBus, WriteEnable, ZeroWord.
- Add RstEnableN (1'b0) for the active-low reset polarity.
- One sub-module: wr_fifo (DEPTH x (AW+DW), count, push/pop, per-entry valid and address export for hazard compare).
- Arbitration, age counter and stall logic stay in the top module.

Test Plan:
- Reset release, then primary pipe_we=1, addr=3, data=0xDEADBEEF -> same cycle we=1, waddr=3, wdata=0xDEADBEEF; lu_ready=1.
- Primary idle, lu push addr=7, data=0x12345678 at cycle N -> we=1, waddr=7, wdata=0x12345678 in cycle N+1; count returns to 0.
- DEPTH=2: push addr 5 then addr 6 while primary busy every cycle -> lu_ready=0 after second push; pend_hit1=1 for raddr1=5; third lu_valid is held off.
- Primary busy continuously with one entry queued -> stall_req=1 on the cycle after age reaches 4. Then drop pipe_we -> head written that cycle; stall_req=0 the next cycle.
- lu push addr=0, data=0xFFFFFFFF -> handshake completes, count stays 0, we never asserted for it. Separately, raddr1=0 -> pend_hit1=0.
- Fill with 2 entries, pulse rst=0 asynchronously mid-cycle -> we=0, lu_ready=0 at once. After release, count=0 and no stale write ever appears.
